alu_flag_unit: RTL
==================

Name: alu_flag_unit

Overview:
- Status-flag side of the ALU interface. Consumes the ALU flag outputs: set_flags, carry_out, zero_out, neg_out.
- Holds the architectural C/Z/N register and drives the ALU carry_in.
- Evaluates branch/predication condition codes against the held flags.
- Provides a small LIFO for saving and restoring flags across calls and interrupts.

Parameters:
- DEPTH, 4, number of entries in the flag save stack (≥1).
- DW, 3, flag word width: bit2=N, bit1=Z, bit0=C. Fixed at 3; exposed for package consistency.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- alu_valid  input  1  ALU result of the current instruction is final this cycle.
- set_flags  input  1  ALU flag-update request.
- carry_out  input  1  ALU carry.
- zero_out  input  1  ALU zero.
- neg_out  input  1  ALU negative.
- flag_write  input  1  explicit status-register write.
- flag_wdata  input  3  data for flag_write.
- push  input  1  save current flags to stack.
- pop  input  1  restore flags from stack.
- clear_err  input  1  clear sticky stack_err.
- carry_mode  input  2  carry_in source select.
- cond  input  4  condition code to evaluate.
- cond_true  output  1  condition result.
- carry_in  output  1  to ALU carry_in.
- flags  output  3  registered {N,Z,C}.
- stack_empty  output  1  depth==0.
- stack_full  output  1  depth==DEPTH.
- stack_err  output  1  sticky overflow/underflow.

Behaviour:
- Reset (async, immediate):
  - flags=000, depth=0, stack_err=0.
  - Hence stack_empty=1, stack_full=0, cond_true per cond with zero flags.
  - Stack entry contents are don't-care.
- Flag register next-value priority (highest first):
  1. flag_write: flags<=flag_wdata.
  2. Valid pop: flags<=top entry.
  3. alu_valid&&set_flags: flags<={neg_out,zero_out,carry_out}.
  4. Otherwise hold.
- All three flags update together on an ALU update. Logical ops therefore clear C, because the ALU reports carry 0 for them.
- set_flags without alu_valid is ignored.
- Stack operations:
  - push only, not full: entry[depth]<=flags (pre-update value this cycle); depth+1.
  - pop only, not empty: depth-1; flags<=entry[depth-1] (subject to flag_write priority).
  - push&&pop, not empty: swap. flags<=top, top<=current flags, depth unchanged.
  - push when full, or pop/swap when empty: no state change, stack_err<=1.
  - stack_err holds until clear_err or reset. Error set beats clear_err in the same cycle.
- carry_in is combinational from the registered flags: 00→0, 01→1, 10→C, 11→~C. The ALU sees the value at the start of the cycle, so there is no same-cycle bypass.
- cond_true is combinational from the registered flags:
  - 0000 AL=1; 0001 NV=0
  - 0010 EQ=Z; 0011 NE=~Z
  - 0100 CS=C; 0101 CC=~C
  - 0110 MI=N; 0111 PL=~N
  - 1000 HI=C&~Z; 1001 LS=~C|Z
  - 1010 POS=~N&~Z; 1011 NPOS=N|Z
  - 1100–1111 reserved=0
- Latency: flag effects are visible on flags and cond_true one clock after the update cycle.
- Reset asserted mid-push/pop: that operation is discarded.

Decomposition:
- Shared package alu_flag_pkg:
  - Condition-code localparams (COND_AL…COND_NPOS).
  - carry_mode constants (CIN_ZERO, CIN_ONE, CIN_FLAG, CIN_NFLAG).
  - Flag bit indices (FLAG_N=2, FLAG_Z=1, FLAG_C=0).
- One sub-module flag_stack: DEPTH×3 LIFO with push/pop/swap, depth counter, full/empty, error pulse.
- The top level holds the flag register, priority mux, carry_in mux and condition decode.

Test Plan:
- Reset then cond=0000 → cond_true=1, flags=000. Then cond=0010 → cond_true=0; carry_mode=01 → carry_in=1.
- alu_valid=1, set_flags=1, {neg,zero,carry}=011 → next cycle flags=011, cond EQ=1, HI=0, carry_mode=10 gives carry_in=1. Then set_flags=0, alu_valid=1 → flags hold 011.
- flags=101; push. flags←010 via flag_write; pop → flags=101, stack_empty=1, stack_err=0.
- DEPTH=4: five pushes → stack_full=1 after 4th, stack_err=1 after 5th, depth stays 4. clear_err → stack_err=0. Pop on empty → stack_err=1.
- Same cycle flag_write=1 (110), pop=1, ALU set 001 → flags=110, depth decremented.
- Swap: stack top=100, flags=011, push&pop → flags=100, top=011, depth unchanged.

Source files
------------

// File: rtl/alu_flag_unit_pkg.sv
// Shared definitions for the ALU flag unit: flag bit indices,
// condition codes and carry_in source selects.
package alu_flag_pkg;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef logic [2:0] flags_t;

  localparam logic [3:0] COND_AL   = 4'b0000;
  localparam logic [3:0] COND_NV   = 4'b0001;
  localparam logic [3:0] COND_EQ   = 4'b0010;
  localparam logic [3:0] COND_NE   = 4'b0011;
  localparam logic [3:0] COND_CS   = 4'b0100;
  localparam logic [3:0] COND_CC   = 4'b0101;
  localparam logic [3:0] COND_MI   = 4'b0110;
  localparam logic [3:0] COND_PL   = 4'b0111;
  localparam logic [3:0] COND_HI   = 4'b1000;
  localparam logic [3:0] COND_LS   = 4'b1001;
  localparam logic [3:0] COND_POS  = 4'b1010;
  localparam logic [3:0] COND_NPOS = 4'b1011;

  localparam logic [1:0] CIN_ZERO  = 2'b00;
  localparam logic [1:0] CIN_ONE   = 2'b01;
  localparam logic [1:0] CIN_FLAG  = 2'b10;
  localparam logic [1:0] CIN_NFLAG = 2'b11;

endpackage

// File: rtl/alu_flag_unit_if.sv
// Flag-unit bus: ALU flag inputs, stack/flag controls, condition
// and carry outputs. master = ALU/control side, slave = flag unit.
interface alu_flag_unit_if #(
  parameter int DW = 3
);
  logic          alu_valid;
  logic          set_flags;
  logic          carry_out;
  logic          zero_out;
  logic          neg_out;
  logic          flag_write;
  logic [DW-1:0] flag_wdata;
  logic          push;
  logic          pop;
  logic          clear_err;
  logic [1:0]    carry_mode;
  logic [3:0]    cond;
  logic          cond_true;
  logic          carry_in;
  logic [DW-1:0] flags;
  logic          stack_empty;
  logic          stack_full;
  logic          stack_err;

  modport master (
    output alu_valid, set_flags, carry_out,
    output zero_out, neg_out,
    output flag_write, flag_wdata,
    output push, pop, clear_err,
    output carry_mode, cond,
    input  cond_true, carry_in, flags,
    input  stack_empty, stack_full, stack_err
  );

  modport slave (
    input  alu_valid, set_flags, carry_out,
    input  zero_out, neg_out,
    input  flag_write, flag_wdata,
    input  push, pop, clear_err,
    input  carry_mode, cond,
    output cond_true, carry_in, flags,
    output stack_empty, stack_full, stack_err
  );

endinterface

// File: rtl/alu_flag_unit_flag_stack.sv
// DEPTH x 3 flag LIFO with push, pop and swap (push&pop).
// Ports: i_push/i_pop/i_data in; o_top, o_load, o_empty, o_full, o_err out.
module flag_stack
  import alu_flag_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_push,
  input  logic   i_pop,
  input  flags_t i_data,
  output flags_t o_top,
  output logic   o_load,
  output logic   o_empty,
  output logic   o_full,
  output logic   o_err
);

  localparam int DPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flags_t         r_mem [DEPTH];
  logic [DPW-1:0] r_depth;

  logic           w_push_only;
  logic           w_pop_only;
  logic           w_swap;
  logic           w_do_push;
  logic           w_do_pop;
  logic           w_do_swap;
  logic [IW-1:0]  w_wr_idx;
  logic [IW-1:0]  w_top_idx;

  assign o_empty     = (r_depth == '0);
  assign o_full      = (r_depth == DPW'(DEPTH));

  assign w_push_only = i_push & ~i_pop;
  assign w_pop_only  = i_pop & ~i_push;
  assign w_swap      = i_push & i_pop;

  assign w_do_push   = w_push_only & ~o_full;
  assign w_do_pop    = w_pop_only & ~o_empty;
  assign w_do_swap   = w_swap & ~o_empty;

  assign o_load      = w_do_pop | w_do_swap;
  assign o_err       = (w_push_only & o_full)
                     | ((w_pop_only | w_swap) & o_empty);

  assign w_wr_idx    = IW'(r_depth);
  // top index wraps when empty; o_load is low then so it is unused
  assign w_top_idx   = IW'(r_depth - DPW'(1));
  assign o_top       = r_mem[w_top_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_depth <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + DPW'(1);
    end else if (w_do_pop) begin
      r_depth <= r_depth - DPW'(1);
    end
  end

  // entry contents need no reset; depth alone defines validity
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_do_push) begin
        r_mem[w_wr_idx] <= i_data;
      end else if (w_do_swap) begin
        r_mem[w_top_idx] <= i_data;
      end
    end
  end

endmodule

// File: rtl/alu_flag_unit.sv
// Architectural N/Z/C register, ALU carry_in mux and condition decode.
// Ports: clk, reset (async, active-high), bus (alu_flag_unit_if.slave).
module alu_flag_unit
  import alu_flag_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 3
) (
  input  logic            clk,
  input  logic            reset,
  alu_flag_unit_if.slave  bus
);

  flags_t r_flags;
  logic   r_err;

  flags_t w_top;
  logic   w_load;
  logic   w_empty;
  logic   w_full;
  logic   w_err_set;
  logic   w_cond;
  logic   w_cin;
  logic   w_n;
  logic   w_z;
  logic   w_c;

  flag_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.push),
    .i_pop   (bus.pop),
    .i_data  (r_flags),
    .o_top   (w_top),
    .o_load  (w_load),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_err   (w_err_set)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else if (bus.flag_write) begin
      r_flags <= bus.flag_wdata[2:0];
    end else if (w_load) begin
      r_flags <= w_top;
    end else if (bus.alu_valid && bus.set_flags) begin
      r_flags <= {bus.neg_out, bus.zero_out, bus.carry_out};
    end
  end

  // a new error wins over clear_err in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (bus.clear_err) begin
      r_err <= 1'b0;
    end
  end

  assign w_n = r_flags[FLAG_N];
  assign w_z = r_flags[FLAG_Z];
  assign w_c = r_flags[FLAG_C];

  always_comb begin
    w_cin = 1'b0;
    unique case (bus.carry_mode)
      CIN_ZERO:  w_cin = 1'b0;
      CIN_ONE:   w_cin = 1'b1;
      CIN_FLAG:  w_cin = w_c;
      CIN_NFLAG: w_cin = ~w_c;
      default:   w_cin = 1'b0;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (bus.cond)
      COND_AL:   w_cond = 1'b1;
      COND_NV:   w_cond = 1'b0;
      COND_EQ:   w_cond = w_z;
      COND_NE:   w_cond = ~w_z;
      COND_CS:   w_cond = w_c;
      COND_CC:   w_cond = ~w_c;
      COND_MI:   w_cond = w_n;
      COND_PL:   w_cond = ~w_n;
      COND_HI:   w_cond = w_c & ~w_z;
      COND_LS:   w_cond = ~w_c | w_z;
      COND_POS:  w_cond = ~w_n & ~w_z;
      COND_NPOS: w_cond = w_n | w_z;
      default:   w_cond = 1'b0;
    endcase
  end

  assign bus.flags       = DW'(r_flags);
  assign bus.cond_true   = w_cond;
  assign bus.carry_in    = w_cin;
  assign bus.stack_empty = w_empty;
  assign bus.stack_full  = w_full;
  assign bus.stack_err   = r_err;

endmodule
